// File: rtl/mux_81.sv
// rtl/mux_81.sv - registered 8-to-1 single-bit multiplexer
//
// Purpose: steers one of eight data bits onto a registered output under a
// 3-bit binary select {s2,s1,s0}. Optional macro MUX_81_PIPE_EN adds an
// input register stage (select and data) ahead of the mux, making the
// latency two cycles instead of one. The port list is the same in both builds.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        synchronous active-low reset; clears all registers to 0
//   s2, s1, s0   select bits, s2 is the MSB
//   i0 .. i7     data inputs; iN is chosen when {s2,s1,s0} = N
//   y            registered selected data bit
module mux_81 (
  input  logic clk,
  input  logic rst_n,
  input  logic s2,
  input  logic s1,
  input  logic s0,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  output logic y
);

  logic [2:0] sel_in;
  logic [7:0] data_in;
  logic [2:0] sel_mux;
  logic [7:0] data_mux;
  logic       mux_bit;

  assign sel_in  = {s2, s1, s0};
  assign data_in = {i7, i6, i5, i4, i3, i2, i1, i0};

`ifdef MUX_81_PIPE_EN
  logic [2:0] sel_q;
  logic [7:0] data_q;

  // Select and data are captured together so the mux never sees a select
  // from one cycle paired with data from another.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q  <= 3'd0;
      data_q <= 8'd0;
    end else begin
      sel_q  <= sel_in;
      data_q <= data_in;
    end
  end

  assign sel_mux  = sel_q;
  assign data_mux = data_q;
`else
  assign sel_mux  = sel_in;
  assign data_mux = data_in;
`endif

  // Full case over all eight codes; every select value is legal.
  always_comb begin
    mux_bit = 1'b0;
    case (sel_mux)
      3'd0: mux_bit = data_mux[0];
      3'd1: mux_bit = data_mux[1];
      3'd2: mux_bit = data_mux[2];
      3'd3: mux_bit = data_mux[3];
      3'd4: mux_bit = data_mux[4];
      3'd5: mux_bit = data_mux[5];
      3'd6: mux_bit = data_mux[6];
      3'd7: mux_bit = data_mux[7];
      default: mux_bit = 1'b0;
    endcase
  end

  // Output register removes any combinational path from inputs to y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y <= 1'b0;
    end else begin
      y <= mux_bit;
    end
  end

endmodule

// File: tb/tb_mux_81.sv
// tb/tb_mux_81.sv - self-checking testbench for mux_81
module tb_mux_81;

`ifdef MUX_81_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s2 = 1'b0, s1 = 1'b0, s0 = 1'b0;
  logic i0 = 1'b0, i1 = 1'b0, i2 = 1'b0, i3 = 1'b0;
  logic i4 = 1'b0, i5 = 1'b0, i6 = 1'b0, i7 = 1'b0;
  logic y;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: the selected bit seen at the previous edge,
  // only used when the input stage is present.
  logic pipe_val = 1'b0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       exp;
  } vec_t;

  vec_t vecs[16];

  mux_81 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s2   (s2),
    .s1   (s1),
    .s0   (s0),
    .i0   (i0),
    .i1   (i1),
    .i2   (i2),
    .i3   (i3),
    .i4   (i4),
    .i5   (i5),
    .i6   (i6),
    .i7   (i7),
    .y    (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: y=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, take the edge, then compare y against the
  // model's view of what the selected input should look like at this edge.
  task automatic step(input logic r, input logic [2:0] sel, input logic [7:0] d,
                      input string tag);
    logic sampled;
    logic exp;
    rst_n = r;
    {s2, s1, s0} = sel;
    {i7, i6, i5, i4, i3, i2, i1, i0} = d;
    @(posedge clk);
    #1;
    sampled = r ? d[sel] : 1'b0;
    if (LAT == 1) begin
      exp = sampled;
    end else begin
      exp      = r ? pipe_val : 1'b0;
      pipe_val = sampled;
    end
    check(tag, y, exp);
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] sel;
    logic       r;

    // Reset held with everything driven high.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 3'd7, 8'hFF, "reset_hold");
      check("reset_y_zero", y, 1'b0);
    end
    step(1'b1, 3'd7, 8'hFF, "release_1");
    if (LAT == 2) begin
      check("release_pipe_first_edge", y, 1'b0);
      step(1'b1, 3'd7, 8'hFF, "release_2");
    end
    check("release_data", y, 1'b1);

    // Reset asserted between edges must not affect y until the next edge.
    rst_n = 1'b0;
    #2;
    check("async_reset_ignored", y, 1'b1);
    rst_n = 1'b1;

    // Exhaustive static: one-hot and one-cold data per select code.
    for (int n = 0; n < 8; n++) begin
      vecs[2*n]     = '{sel: 3'(n), data: 8'(1 << n),    exp: 1'b1};
      vecs[2*n + 1] = '{sel: 3'(n), data: ~8'(1 << n),   exp: 1'b0};
    end
    foreach (vecs[v]) begin
      for (int k = 0; k < LAT; k++) step(1'b1, vecs[v].sel, vecs[v].data, "static_model");
      check($sformatf("static_sel%0d_%s", vecs[v].sel, vecs[v].exp ? "hot" : "cold"),
            y, vecs[v].exp);
    end

    // Select bit ordering: MSB vs LSB.
    for (int k = 0; k < LAT; k++) step(1'b1, 3'b100, 8'b0001_0000, "order_model");
    check("order_sel100", y, 1'b1);
    for (int k = 0; k < LAT; k++) step(1'b1, 3'b001, 8'b0001_0000, "order_model");
    check("order_sel001", y, 1'b0);

    // Simultaneous select and data change: y stays 1 throughout.
    for (int k = 0; k < LAT; k++) step(1'b1, 3'd3, 8'b0000_1000, "simul_pre");
    check("simul_before", y, 1'b1);
    for (int k = 0; k < LAT; k++) begin
      step(1'b1, 3'd5, 8'b0010_0000, "simul_model");
      check("simul_no_glitch", y, 1'b1);
    end

    // Binary-counting sweep with a one-cycle reset pulse part way through.
    for (int c = 0; c < 2048; c++) begin
      d   = 8'(c);
      sel = 3'(c >> 8);
      r   = (c == 1000) ? 1'b0 : 1'b1;
      step(r, sel, d, "sweep");
      if (c == 1000) check("sweep_reset_pulse", y, 1'b0);
    end

    // Random stimulus with occasional reset.
    for (int c = 0; c < 400; c++) begin
      d   = 8'($urandom);
      sel = 3'($urandom_range(0, 7));
      r   = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
      step(r, sel, d, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_81.md
# mux_81

Registered 8-to-1 single-bit multiplexer. A 3-bit select formed from `s2` (MSB), `s1` and `s0` (LSB) picks one of eight data inputs `i0`–`i7` and drives it onto `y` through an output register. It is a leaf datapath block used wherever a one-bit signal must be steered from eight sources under a binary select in a single clock domain.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock for all state.
- `rst_n`  input  1  reset; one clock, reset is synchronous and active-low.
- `s2`  input  1  select bit 2 (MSB).
- `s1`  input  1  select bit 1.
- `s0`  input  1  select bit 0 (LSB).
- `i0`…`i7`  input  1 each  data inputs; `iN` is selected when {s2,s1,s0} = N.
- `y`  output  1  registered selected data bit.

## Operation
- sel = {s2,s1,s0}, unsigned 0–7; all 8 codes are valid, no illegal code.
- Mapping: 0→i0, 1→i1, 2→i2, 3→i3, 4→i4, 5→i5, 6→i6, 7→i7.
- Each rising `clk` edge with `rst_n`=1: `y` <= i[sel] sampled at that edge.
- Each rising `clk` edge with `rst_n`=0: `y` <= 0, regardless of select or data.
- Select and data are sampled together at the same edge. There is no glitch path from inputs to `y`.
- There is no enable. `y` updates every cycle.

## Timing
- Reset value: `y` = 0. It is applied only at a clock edge. Asserting `rst_n` between edges has no effect until the next edge.
- Latency: 1 cycle from input and select to `y` in default build, 2 cycles with `MUX_81_PIPE_EN`.
- Simultaneous select and data change: the value on the inputs at the sampling edge wins. No old/new mixing.
- Reset mid-stream: `y`=0 from the first edge with `rst_n`=0. On the first edge with `rst_n`=1, `y` = i[sel] in default build. With pipeline, see Configuration.
- Inputs are assumed synchronous to `clk`. No internal synchronizers.

## Configuration
- Macro `MUX_81_PIPE_EN`:
  - Undefined (default): one register stage, on `y` only. Latency 1.
  - Defined: an additional input stage registers `{s2,s1,s0}` and `i0`–`i7` every cycle. The mux operates on the registered values, and `y` is registered as before. Latency 2.
  - Defined, reset behaviour: `rst_n`=0 clears all input-stage registers and `y` to 0. After release, `y` is 0 on the first edge with `rst_n`=1 and shows valid data from the second edge.
- The port list is identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 with all inputs 1 and sel=7 for 3 edges, then `y`=0 at each edge. Release with sel=7 and i7=1, then `y`=1 after 1 edge (2 edges with `MUX_81_PIPE_EN`).
- Exhaustive static: for each sel 0–7, drive only iN=1 where N=sel and all others 0. `y`=1 after the latency. Drive iN=0 with all others 1, and `y`=0.
- Binary-counting sweep: i0 toggles every cycle, iK toggles every 2^K cycles. Sel increments every 256 cycles, with s0 the fastest, then s1 (512), then s2 (1024), over 2048 cycles. `y` must equal the delayed i[sel] every cycle, with period doubling per select step.
- Select bit ordering: sel {s2,s1,s0}=100 with i4=1 and i1=0, then `y`=1. Sel=001 with i1=0 and i4=1, then `y`=0. Distinguishes MSB from LSB.
- Simultaneous change: at one edge switch sel 3→5 while i3 goes 1→0 and i5 goes 0→1. `y` = 1, the new i5, after the latency, with no intermediate value.
- Mid-run reset: during the sweep, pulse `rst_n`=0 for 1 cycle. `y`=0 for exactly that edge, then resumes tracking i[sel] per the latency rules.
